// File: rtl/syn_lb_byte_master.sv
`default_nettype none
// ============================================================================
// syn_lb_byte_master - byte-stream command parser that masters the local bus
// Rev 1.0
// ============================================================================
module syn_lb_byte_master #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 8,
    parameter int RD_TIMEOUT = 255
) (
    input  logic              clk_ir,
    input  logic              rst_ih,
    input  logic [7:0]        rx_byte_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic [7:0]        tx_byte_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic              lb_rd_en_o,
    output logic              lb_wr_en_o,
    output logic [ADDR_W-1:0] lb_addr_o,
    output logic              lb_wr_valid_o,
    output logic [DATA_W-1:0] lb_wr_data_o,
    input  logic              lb_rd_valid_i,
    input  logic [DATA_W-1:0] lb_rd_data_i,
    output logic              busy_o
);
    localparam int         NB       = DATA_W / 8;
    localparam int         CW       = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [7:0] OP_WR    = 8'h01;
    localparam logic [7:0] OP_RD    = 8'h02;
    localparam logic [CW-1:0] LAST_BYTE = CW'(NB - 1);
    localparam logic [15:0]   TMO_LAST  = 16'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, GET_ADDR, GET_DATA, ISSUE_WR, ISSUE_RD, WAIT_RD, SEND_STATUS, SEND_DATA
    } state_t;

    state_t            state, state_nxt;
    logic              is_rd, is_rd_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic [DATA_W-1:0] data, data_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [15:0]       tmo, tmo_nxt;
    logic [7:0]        status, status_nxt;

    logic              rx_ready_nxt, tx_valid_nxt, rd_en_nxt, wr_en_nxt, busy_nxt;
    logic [7:0]        tx_byte_nxt;
    logic [ADDR_W-1:0] lb_addr_nxt;
    logic [DATA_W-1:0] lb_wr_data_nxt;

    logic rx_fire, tx_fire;
    assign rx_fire = rx_valid_i & rx_ready_o;
    assign tx_fire = tx_valid_o & tx_ready_i;

    always_ff @(posedge clk_ir or posedge rst_ih) begin
        if (rst_ih) begin
            state         <= IDLE;
            is_rd         <= 1'b0;
            addr          <= '0;
            data          <= '0;
            cnt           <= '0;
            tmo           <= '0;
            status        <= '0;
            rx_ready_o    <= 1'b0;
            tx_valid_o    <= 1'b0;
            tx_byte_o     <= '0;
            lb_rd_en_o    <= 1'b0;
            lb_wr_en_o    <= 1'b0;
            lb_wr_valid_o <= 1'b0;
            lb_addr_o     <= '0;
            lb_wr_data_o  <= '0;
            busy_o        <= 1'b0;
        end else begin
            state         <= state_nxt;
            is_rd         <= is_rd_nxt;
            addr          <= addr_nxt;
            data          <= data_nxt;
            cnt           <= cnt_nxt;
            tmo           <= tmo_nxt;
            status        <= status_nxt;
            rx_ready_o    <= rx_ready_nxt;
            tx_valid_o    <= tx_valid_nxt;
            tx_byte_o     <= tx_byte_nxt;
            lb_rd_en_o    <= rd_en_nxt;
            lb_wr_en_o    <= wr_en_nxt;
            lb_wr_valid_o <= wr_en_nxt;
            lb_addr_o     <= lb_addr_nxt;
            lb_wr_data_o  <= lb_wr_data_nxt;
            busy_o        <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        is_rd_nxt  = is_rd;
        addr_nxt   = addr;
        data_nxt   = data;
        cnt_nxt    = cnt;
        tmo_nxt    = tmo;
        status_nxt = status;

        case (state)
            IDLE: begin
                if (rx_fire) begin
                    if (rx_byte_i == OP_WR || rx_byte_i == OP_RD) begin
                        is_rd_nxt = (rx_byte_i == OP_RD);
                        state_nxt = GET_ADDR;
                    end else begin
                        is_rd_nxt  = 1'b0;
                        status_nxt = 8'hFF;
                        state_nxt  = SEND_STATUS;
                    end
                end
            end
            GET_ADDR: begin
                if (rx_fire) begin
                    addr_nxt = rx_byte_i[ADDR_W-1:0];
                    cnt_nxt  = '0;
                    state_nxt = is_rd ? ISSUE_RD : GET_DATA;
                end
            end
            GET_DATA: begin
                if (rx_fire) begin
                    data_nxt = (data << 8) | DATA_W'(rx_byte_i);
                    cnt_nxt  = cnt + 1'b1;
                    if (cnt == LAST_BYTE) begin
                        state_nxt = ISSUE_WR;
                    end
                end
            end
            ISSUE_WR: begin
                status_nxt = 8'h00;
                state_nxt  = SEND_STATUS;
            end
            ISSUE_RD: begin
                tmo_nxt   = '0;
                state_nxt = WAIT_RD;
            end
            WAIT_RD: begin
                // A response in the final counted cycle still beats the timeout.
                if (lb_rd_valid_i) begin
                    data_nxt   = lb_rd_data_i;
                    status_nxt = 8'h00;
                    state_nxt  = SEND_STATUS;
                end else if (tmo == TMO_LAST) begin
                    data_nxt   = '0;
                    status_nxt = 8'h01;
                    state_nxt  = SEND_STATUS;
                end else begin
                    tmo_nxt = tmo + 16'd1;
                end
            end
            SEND_STATUS: begin
                if (tx_fire) begin
                    cnt_nxt   = '0;
                    state_nxt = is_rd ? SEND_DATA : IDLE;
                end
            end
            SEND_DATA: begin
                if (tx_fire) begin
                    data_nxt = data << 8;
                    cnt_nxt  = cnt + 1'b1;
                    if (cnt == LAST_BYTE) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Outputs are decoded from the next state so they come straight from flops.
        rx_ready_nxt   = (state_nxt == IDLE) || (state_nxt == GET_ADDR) || (state_nxt == GET_DATA);
        tx_valid_nxt   = (state_nxt == SEND_STATUS) || (state_nxt == SEND_DATA);
        rd_en_nxt      = (state_nxt == ISSUE_RD);
        wr_en_nxt      = (state_nxt == ISSUE_WR);
        busy_nxt       = (state_nxt != IDLE);
        tx_byte_nxt    = 8'h00;
        lb_addr_nxt    = lb_addr_o;
        lb_wr_data_nxt = lb_wr_data_o;
        if (state_nxt == SEND_STATUS) begin
            tx_byte_nxt = status_nxt;
        end else if (state_nxt == SEND_DATA) begin
            tx_byte_nxt = data_nxt[DATA_W-1 -: 8];
        end
        if (rd_en_nxt || wr_en_nxt) begin
            lb_addr_nxt = addr_nxt;
        end
        if (wr_en_nxt) begin
            lb_wr_data_nxt = data_nxt;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_syn_lb_byte_master.sv
`default_nettype none
// ============================================================================
// tb_syn_lb_byte_master - table-driven and randomized bench with a command model
// Rev 1.0
// ============================================================================
module tb_syn_lb_byte_master;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 8;
    localparam int RD_TIMEOUT = 8;
    localparam int NB         = DATA_W / 8;

    logic              clk_ir        = 1'b0;
    logic              rst_ih        = 1'b0;
    logic [7:0]        rx_byte_i     = 8'h00;
    logic              rx_valid_i    = 1'b0;
    logic              rx_ready_o;
    logic [7:0]        tx_byte_o;
    logic              tx_valid_o;
    logic              tx_ready_i    = 1'b0;
    logic              lb_rd_en_o;
    logic              lb_wr_en_o;
    logic [ADDR_W-1:0] lb_addr_o;
    logic              lb_wr_valid_o;
    logic [DATA_W-1:0] lb_wr_data_o;
    logic              lb_rd_valid_i = 1'b0;
    logic [DATA_W-1:0] lb_rd_data_i  = '0;
    logic              busy_o;

    syn_lb_byte_master #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_TIMEOUT(RD_TIMEOUT)) dut (
        .clk_ir(clk_ir), .rst_ih(rst_ih),
        .rx_byte_i(rx_byte_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
        .tx_byte_o(tx_byte_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .lb_rd_en_o(lb_rd_en_o), .lb_wr_en_o(lb_wr_en_o), .lb_addr_o(lb_addr_o),
        .lb_wr_valid_o(lb_wr_valid_o), .lb_wr_data_o(lb_wr_data_o),
        .lb_rd_valid_i(lb_rd_valid_i), .lb_rd_data_i(lb_rd_data_i), .busy_o(busy_o)
    );

    always #5 clk_ir = ~clk_ir;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int          slave_delay = 0;
    logic [31:0] slave_word  = '0;
    int          rdy_mode    = 0;

    logic [7:0]  tx_q[$];
    logic [39:0] wr_q[$];
    logic [7:0]  rd_q[$];
    logic [7:0]  exp_tx[$];
    logic [39:0] exp_wr[$];
    logic [7:0]  exp_rd[$];

    logic       hold_pend = 1'b0;
    logic [7:0] hold_byte = 8'h00;
    logic       txv_prev  = 1'b0;
    logic       wr_prev   = 1'b0;
    int         rx_cyc    = -10;
    int         rd_cyc    = 0;
    int         txv_cyc   = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(posedge clk_ir) cyc <= cyc + 1;

    always @(posedge clk_ir) begin
        #1;
        tx_ready_i <= (rdy_mode == 0) ? 1'b1 : (cyc % 3 == 0);
    end

    // Bus and tx monitor, sampled mid-cycle.
    always @(negedge clk_ir) begin
        if (hold_pend) chk("tx_hold", {tx_valid_o, tx_byte_o}, {1'b1, hold_byte});
        hold_pend <= tx_valid_o & ~tx_ready_i;
        hold_byte <= tx_byte_o;
        if (tx_valid_o & tx_ready_i) tx_q.push_back(tx_byte_o);
        if (tx_valid_o & ~txv_prev) txv_cyc <= cyc;
        txv_prev <= tx_valid_o;
        if (rx_valid_i & rx_ready_o) rx_cyc <= cyc;
        if (wr_prev) chk("wr_status_next", {tx_valid_o, tx_byte_o}, 9'h100);
        wr_prev <= lb_wr_en_o;
        if (lb_wr_en_o | lb_wr_valid_o) begin
            chk("wr_valid_eq_en", lb_wr_valid_o, lb_wr_en_o);
            chk("wr_latency", cyc, rx_cyc + 1);
            wr_q.push_back({lb_addr_o, lb_wr_data_o});
        end
        if (lb_rd_en_o) begin
            chk("rd_wr_excl", lb_wr_en_o, 0);
            rd_q.push_back(lb_addr_o);
            rd_cyc <= cyc;
        end
    end

    // Slave answers slave_delay cycles after the strobe; 0 means silent.
    always @(negedge clk_ir) begin
        if (lb_rd_en_o && slave_delay > 0) begin
            repeat (slave_delay) @(posedge clk_ir);
            #1;
            lb_rd_valid_i = 1'b1;
            lb_rd_data_i  = slave_word;
            @(posedge clk_ir);
            #1;
            lb_rd_valid_i = 1'b0;
        end
    end

    // Reference: walk the command stream and list what must appear on tx and the bus.
    task automatic model(input logic [7:0] cmd[$], input int dly, input logic [31:0] word);
        int          i;
        logic [7:0]  op;
        logic [31:0] d;
        bit          ok;
        exp_tx.delete(); exp_wr.delete(); exp_rd.delete();
        i = 0;
        while (i < cmd.size()) begin
            op = cmd[i];
            i++;
            if (op == 8'h01) begin
                d = 0;
                for (int k = 0; k < NB; k++) d = (d << 8) | 32'(cmd[i + 1 + k]);
                exp_wr.push_back({cmd[i], d});
                exp_tx.push_back(8'h00);
                i += 1 + NB;
            end else if (op == 8'h02) begin
                exp_rd.push_back(cmd[i]);
                i++;
                ok = (dly >= 1) && (dly <= RD_TIMEOUT);
                d  = ok ? word : 32'h0;
                exp_tx.push_back(ok ? 8'h00 : 8'h01);
                for (int k = NB - 1; k >= 0; k--) exp_tx.push_back(d[8*k +: 8]);
            end else begin
                exp_tx.push_back(8'hFF);
            end
        end
    endtask

    task automatic send_bytes(input logic [7:0] q[$], input bit gaps);
        int n;
        @(posedge clk_ir); #1;
        for (int i = 0; i < q.size(); i++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                rx_valid_i = 1'b0;
                repeat ($urandom_range(1, 3)) begin @(posedge clk_ir); #1; end
            end
            rx_valid_i = 1'b1;
            rx_byte_i  = q[i];
            n = 0;
            do begin @(negedge clk_ir); n++; end while (!rx_ready_o && n < 400);
            if (!rx_ready_o) begin
                chk("rx_accept_timeout", 0, 1);
                rx_valid_i = 1'b0;
                return;
            end
            @(posedge clk_ir); #1;
        end
        rx_valid_i = 1'b0;
    endtask

    task automatic run(input logic [7:0] cmd[$], input int dly, input logic [31:0] word,
                       input int mode, input bit gaps, input bit use_tab, input logic [7:0] tab_tx[$]);
        int n;
        model(cmd, dly, word);
        if (use_tab) exp_tx = tab_tx;
        slave_delay = dly;
        slave_word  = word;
        rdy_mode    = mode;
        tx_q.delete(); wr_q.delete(); rd_q.delete();
        send_bytes(cmd, gaps);
        n = 0;
        while (tx_q.size() < exp_tx.size() && n < 1000) begin @(negedge clk_ir); n++; end
        repeat (4) @(negedge clk_ir);
        chk("tx_count", tx_q.size(), exp_tx.size());
        for (int i = 0; i < tx_q.size() && i < exp_tx.size(); i++) chk("tx_byte", tx_q[i], exp_tx[i]);
        chk("wr_count", wr_q.size(), exp_wr.size());
        for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++) chk("wr_addr_data", wr_q[i], exp_wr[i]);
        chk("rd_count", rd_q.size(), exp_rd.size());
        for (int i = 0; i < rd_q.size() && i < exp_rd.size(); i++) chk("rd_addr", rd_q[i], exp_rd[i]);
        chk("busy_idle", busy_o, 0);
    endtask

    typedef struct {
        logic [7:0]  cmd[8];
        int          n;
        int          dly;
        logic [31:0] word;
        int          mode;
        bit          gaps;
        logic [7:0]  tx[6];
        int          ntx;
    } vec_t;

    vec_t tab[8];

    initial begin
        logic [7:0]  q[$];
        logic [7:0]  tq[$];
        logic [7:0]  none[$];
        int          lat, kind;
        logic [7:0]  a, badop;
        logic [31:0] w;

        tab[0].cmd = '{8'h01, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00}; tab[0].n = 6;
        tab[0].dly = 3; tab[0].word = 32'h0; tab[0].mode = 0; tab[0].gaps = 0;
        tab[0].tx = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; tab[0].ntx = 1;
        tab[1].cmd = '{8'h02, 8'h24, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; tab[1].n = 2;
        tab[1].dly = 3; tab[1].word = 32'h12345678; tab[1].mode = 0; tab[1].gaps = 0;
        tab[1].tx = '{8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00}; tab[1].ntx = 5;
        tab[2].cmd = '{8'h02, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; tab[2].n = 2;
        tab[2].dly = 0; tab[2].word = 32'hDEADDEAD; tab[2].mode = 0; tab[2].gaps = 0;
        tab[2].tx = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; tab[2].ntx = 5;
        tab[3].cmd = '{8'h02, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; tab[3].n = 2;
        tab[3].dly = 11; tab[3].word = 32'h55AA55AA; tab[3].mode = 0; tab[3].gaps = 0;
        tab[3].tx = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; tab[3].ntx = 5;
        tab[4].cmd = '{8'h7F, 8'h02, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; tab[4].n = 3;
        tab[4].dly = 1; tab[4].word = 32'hA5A50F0F; tab[4].mode = 0; tab[4].gaps = 0;
        tab[4].tx = '{8'hFF, 8'h00, 8'hA5, 8'hA5, 8'h0F, 8'h0F}; tab[4].ntx = 6;
        tab[5].cmd = '{8'h02, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; tab[5].n = 2;
        tab[5].dly = RD_TIMEOUT; tab[5].word = 32'h87654321; tab[5].mode = 0; tab[5].gaps = 0;
        tab[5].tx = '{8'h00, 8'h87, 8'h65, 8'h43, 8'h21, 8'h00}; tab[5].ntx = 5;
        tab[6].cmd = '{8'h02, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; tab[6].n = 2;
        tab[6].dly = 2; tab[6].word = 32'hCAFEF00D; tab[6].mode = 1; tab[6].gaps = 0;
        tab[6].tx = '{8'h00, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h00}; tab[6].ntx = 5;
        tab[7].cmd = '{8'h01, 8'h66, 8'h01, 8'h23, 8'h45, 8'h67, 8'h00, 8'h00}; tab[7].n = 6;
        tab[7].dly = 0; tab[7].word = 32'h0; tab[7].mode = 1; tab[7].gaps = 1;
        tab[7].tx = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; tab[7].ntx = 1;

        // Reset state
        #1 rst_ih = 1'b1;
        repeat (3) @(negedge clk_ir);
        chk("reset_outputs", {rx_ready_o, tx_valid_o, tx_byte_o, lb_rd_en_o, lb_wr_en_o, lb_addr_o,
                              lb_wr_valid_o, lb_wr_data_o, busy_o}, 0);
        @(posedge clk_ir); #2 rst_ih = 1'b0;
        repeat (2) @(negedge clk_ir);
        chk("idle_ready", {rx_ready_o, busy_o}, 2'b10);

        for (int v = 0; v < 8; v++) begin
            q.delete(); tq.delete();
            for (int i = 0; i < tab[v].n; i++) q.push_back(tab[v].cmd[i]);
            for (int i = 0; i < tab[v].ntx; i++) tq.push_back(tab[v].tx[i]);
            run(q, tab[v].dly, tab[v].word, tab[v].mode, tab[v].gaps, 1'b1, tq);
            if (v == 2) begin
                lat = txv_cyc - rd_cyc;
                chk("timeout_latency", (lat >= RD_TIMEOUT) && (lat <= RD_TIMEOUT + 1), 1);
            end
        end

        // Reset in the middle of a write's data bytes
        rdy_mode = 0;
        tx_q.delete(); wr_q.delete(); rd_q.delete();
        q = '{8'h01, 8'h77, 8'h11};
        send_bytes(q, 1'b0);
        #2 rst_ih = 1'b1;
        #1 chk("async_reset_outputs", {rx_ready_o, tx_valid_o, tx_byte_o, lb_rd_en_o, lb_wr_en_o,
                                       lb_addr_o, lb_wr_valid_o, lb_wr_data_o, busy_o}, 0);
        @(posedge clk_ir); #2 rst_ih = 1'b0;
        repeat (3) @(negedge clk_ir);
        chk("no_write_after_reset", wr_q.size(), 0);
        chk("ready_after_reset", {rx_ready_o, busy_o}, 2'b10);
        q = '{8'h01, 8'h12, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
        run(q, 0, 32'h0, 0, 1'b0, 1'b0, none);

        // Randomized command streams against the model
        for (int it = 0; it < 24; it++) begin
            q.delete();
            kind = $urandom_range(0, 9);
            a    = 8'($urandom);
            w    = $urandom;
            if (kind <= 3) begin
                q.push_back(8'h01); q.push_back(a);
                for (int k = NB - 1; k >= 0; k--) q.push_back(w[8*k +: 8]);
            end else begin
                if (kind >= 8) begin
                    badop = 8'($urandom);
                    if (badop == 8'h01 || badop == 8'h02) badop = 8'h80;
                    q.push_back(badop);
                end
                q.push_back(8'h02); q.push_back(a);
            end
            run(q, $urandom_range(0, 11), $urandom, $urandom_range(0, 1), 1'($urandom_range(0, 1)), 1'b0, none);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/syn_lb_byte_master.md
Name: syn_lb_byte_master

Overview:
- Upstream stage that drives the internal local bus as master.
- Parses a byte-stream command protocol, typically from the host UART RX path, into single local-bus read/write transactions.
- Returns status and read data as a byte stream, typically to the UART TX path.
- Connects on its bus side directly to the local-bus master modport (rd_en, wr_en, addr, wr_valid, wr_data out; rd_valid, rd_data in).

Parameters:
DATA_W, 32, local-bus data width; must be a multiple of 8; NB = DATA_W/8 data bytes per word.
ADDR_W, 8, local-bus address width; must be ≤ 8; taken from bits [ADDR_W-1:0] of the address byte.
RD_TIMEOUT, 255, cycles to wait for lb_rd_valid_i after lb_rd_en_o before declaring timeout; 1..65535.

Ports:
clk_ir  in  1  system clock; all logic on rising edge.
rst_ih  in  1  asynchronous, active-high reset.
rx_byte_i  in  8  command byte.
rx_valid_i  in  1  rx_byte_i valid.
rx_ready_o  out  1  byte accepted when rx_valid_i & rx_ready_o.
tx_byte_o  out  8  response byte.
tx_valid_o  out  1  tx_byte_o valid.
tx_ready_i  in  1  byte taken when tx_valid_o & tx_ready_i.
lb_rd_en_o  out  1  read strobe.
lb_wr_en_o  out  1  write strobe.
lb_addr_o  out  ADDR_W  transaction address.
lb_wr_valid_o  out  1  write data valid.
lb_wr_data_o  out  DATA_W  write data.
lb_rd_valid_i  in  1  read data valid from slave.
lb_rd_data_i  in  DATA_W  read data from slave.
busy_o  out  1  high whenever FSM not in IDLE.

Behaviour:
- Reset (async assert, sync release): all outputs 0; FSM = IDLE; internal addr/data/timeout registers 0.
- All outputs registered.
- Protocol:
  - Opcode 0x01 = write: followed by addr byte, then NB data bytes MSB first.
  - Opcode 0x02 = read: followed by addr byte.
- FSM states:
  - IDLE: rx_ready_o=1; on accepted byte: 0x01/0x02 -> GET_ADDR, latch op; any other value -> SEND_STATUS with status 0xFF.
  - GET_ADDR: rx_ready_o=1; accept byte, latch addr; write -> GET_DATA (byte counter=0); read -> ISSUE_RD.
  - GET_DATA: rx_ready_o=1; shift accepted bytes into the data register (left shift, new byte in LSBs); after the NB-th byte -> ISSUE_WR.
  - ISSUE_WR: for exactly one cycle, lb_wr_en_o=1 and lb_wr_valid_o=1 with lb_addr_o/lb_wr_data_o valid. Status=0x00 -> SEND_STATUS.
  - ISSUE_RD: one-cycle lb_rd_en_o=1 with lb_addr_o valid; clear timeout counter -> WAIT_RD.
  - WAIT_RD: lb_rd_valid_i=1 -> latch lb_rd_data_i, status 0x00 -> SEND_STATUS. Otherwise increment counter; at count == RD_TIMEOUT-1 with no valid -> data=0, status 0x01 -> SEND_STATUS. If valid arrives in the same cycle the count is reached, valid wins.
  - SEND_STATUS: tx_valid_o=1, tx_byte_o=status; hold stable until tx_ready_i. Then: read -> SEND_DATA (counter=0); write or error -> IDLE.
  - SEND_DATA: send NB bytes of latched data MSB first, each held until tx_ready_i; after the last -> IDLE.
- rx_ready_o=0 outside IDLE/GET_ADDR/GET_DATA; rx bytes arriving then are not accepted (back-pressure, no drop).
- lb_rd_valid_i outside WAIT_RD, including in the ISSUE_RD cycle itself, is ignored. Earliest honoured response is the cycle after lb_rd_en_o.
- lb_rd_en_o and lb_wr_en_o are never high together and never high for more than one cycle per command.
- lb_addr_o and lb_wr_data_o hold their last values between transactions.
- Reset mid-command: the partial command is discarded, and any strobe or tx byte in progress is deasserted immediately (async).
- Throughput: one byte per cycle on rx and tx when the partner is always ready.
- Write latency: last data byte accepted -> lb_wr_en_o next cycle -> status byte valid the cycle after.

Test Plan:
- Write, always-ready: rx 01,10,DE,AD,BE,EF -> one-cycle lb_wr_en_o=lb_wr_valid_o=1, addr 0x10, wr_data 0xDEADBEEF; tx 00; busy_o low afterwards.
- Read: rx 02,24; slave returns 0x12345678 three cycles after lb_rd_en_o -> tx 00,12,34,56,78 in order; lb_rd_en_o high exactly one cycle with addr 0x24.
- Read timeout, RD_TIMEOUT=8, slave silent -> tx 01,00,00,00,00 with status valid 8 cycles after the strobe; a late lb_rd_valid_i is ignored and the next command parses correctly.
- Invalid opcode: rx 7F then 02,05 -> tx FF, followed by a normal read of addr 0x05; no lb strobe for 0x7F.
- Back-pressure: tx_ready_i toggling 1-of-3 cycles during a read response, and rx_valid_i gapped during a write -> tx_byte_o stable while unaccepted, no byte lost or duplicated, correct data on the bus.
- rst_ih pulsed after 3 write bytes -> outputs 0 at once, no lb_wr_en_o; a subsequent full write executes correctly.
